// File: rtl/bcd_press_counter_if.sv
// Signal bundle between the push-button press counter and its user.
// The master side owns the raw button pin and the clear request; the slave
// side (the counter) returns the packed BCD count and the event strobes.
interface bcd_press_counter_if;
    logic        btn_raw;
    logic        clr;
    logic [15:0] num;
    logic        pressed;
    logic        press_pulse;
    logic        overflow;

    modport master (
        output btn_raw,
        output clr,
        input  num,
        input  pressed,
        input  press_pulse,
        input  overflow
    );

    modport slave (
        input  btn_raw,
        input  clr,
        output num,
        output pressed,
        output press_pulse,
        output overflow
    );
endinterface

// File: rtl/bcd_press_counter.sv
// Push-button press counter feeding the 4-digit multiplexed 7-segment driver.
// The raw pin is synchronised through two flops, debounced with a 20-bit
// stability counter, and every accepted press adds one to a 4-digit packed
// BCD count (0000-9999, wrapping with a one-cycle overflow strobe).
// num[15:12] is the leftmost display digit, num[3:0] the rightmost.
//
// Optional feature, macro BCD_PRESS_AUTO_REPEAT_EN:
//   defined   - holding the button issues extra increments: one after
//               HOLD_CYCLES, then one every REPEAT_CYCLES while still held.
//   undefined - exactly one increment per debounced press.
module bcd_press_counter #(
    parameter int DEBOUNCE_CYCLES = 160000,
    parameter bit ACTIVE_HIGH     = 1'b1,
    parameter int HOLD_CYCLES     = 8000000,
    parameter int REPEAT_CYCLES   = 1600000
) (
    input logic                CLK,
    input logic                RST_N,
    bcd_press_counter_if.slave bus
);

    localparam logic [19:0] DCNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

    logic        btn_in;
    logic        sync_q;
    logic        btn_s;
    logic [19:0] dcnt;
    logic        pressed_q;
    logic        press_accept;
    logic        inc_event;

    logic [15:0] num_q;
    logic [15:0] num_inc;
    logic        num_wrap;
    logic        press_pulse_q;
    logic        overflow_q;

    logic        bcd_carry;
    logic [3:0]  bcd_digit;

    // Normalise the pin so that 1 always means "pressed" from here on.
    assign btn_in = ACTIVE_HIGH ? bus.btn_raw : ~bus.btn_raw;

    // Two-flop synchroniser; both stages come out of reset at the released level.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_q <= btn_in;
            btn_s  <= sync_q;
        end
    end

    // Debounce: the level must differ from pressed for DEBOUNCE_CYCLES
    // consecutive cycles before it is accepted; any agreeing cycle restarts it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dcnt      <= 20'd0;
            pressed_q <= 1'b0;
        end else if (btn_s == pressed_q) begin
            dcnt <= 20'd0;
        end else if (dcnt == DCNT_LAST) begin
            pressed_q <= btn_s;
            dcnt      <= 20'd0;
        end else begin
            dcnt <= dcnt + 20'd1;
        end
    end

    // A press is the edge on which pressed is about to go 0 -> 1, so the
    // strobe and the new count appear in the same cycle as pressed itself.
    assign press_accept = btn_s && !pressed_q && (dcnt == DCNT_LAST);

`ifdef BCD_PRESS_AUTO_REPEAT_EN

    localparam logic [23:0] HOLD_LAST   = 24'(HOLD_CYCLES - 1);
    localparam logic [23:0] REPEAT_LAST = 24'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } rpt_state_t;

    rpt_state_t  state_q;
    rpt_state_t  state_d;
    logic [23:0] timer_q;
    logic [23:0] timer_d;
    logic        repeat_event;

    // Auto-repeat state and timer registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            timer_q <= 24'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Auto-repeat sequencing: wait out the hold delay, then fire periodically
    // until the debounced level drops, which silently returns to IDLE.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        repeat_event = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_accept) begin
                    state_d = HOLD;
                    timer_d = 24'd0;
                end
            end
            HOLD: begin
                if (!pressed_q) begin
                    state_d = IDLE;
                    timer_d = 24'd0;
                end else if (timer_q == HOLD_LAST) begin
                    repeat_event = 1'b1;
                    state_d      = REPEAT;
                    timer_d      = 24'd0;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end
            REPEAT: begin
                if (!pressed_q) begin
                    state_d = IDLE;
                    timer_d = 24'd0;
                end else if (timer_q == REPEAT_LAST) begin
                    repeat_event = 1'b1;
                    timer_d      = 24'd0;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = 24'd0;
            end
        endcase
    end

    assign inc_event = press_accept | repeat_event;

`else

    // Without auto-repeat the hold/repeat timings have no hardware to drive.
    logic unused_cfg;
    assign unused_cfg = (HOLD_CYCLES == REPEAT_CYCLES);

    assign inc_event = press_accept;

`endif

    // BCD increment: ripple a carry through the four digits, a 9 rolling to
    // 0 and passing the carry on; a carry out of the top digit is the wrap.
    always_comb begin
        num_inc   = num_q;
        bcd_carry = 1'b1;
        bcd_digit = 4'd0;
        for (int d = 0; d < 4; d++) begin
            bcd_digit = num_q[4*d +: 4];
            if (bcd_carry) begin
                if (bcd_digit >= 4'd9) begin
                    num_inc[4*d +: 4] = 4'd0;
                end else begin
                    num_inc[4*d +: 4] = bcd_digit + 4'd1;
                    bcd_carry         = 1'b0;
                end
            end
        end
        num_wrap = bcd_carry;
    end

    // Count register and strobes; clear beats a same-cycle increment but the
    // press strobe still reports the event.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            num_q         <= 16'h0000;
            press_pulse_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            press_pulse_q <= inc_event;
            if (bus.clr) begin
                num_q      <= 16'h0000;
                overflow_q <= 1'b0;
            end else if (inc_event) begin
                num_q      <= num_inc;
                overflow_q <= num_wrap;
            end else begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign bus.num         = num_q;
    assign bus.pressed     = pressed_q;
    assign bus.press_pulse = press_pulse_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_bcd_press_counter.sv
// Self-checking bench for bcd_press_counter.
// Instance a: main unit (active-high pin), table vectors plus corner sequences,
//             every press strobe checked against a scoreboard of expected counts.
// Instance b: active-low pin.
// Instance c: shortest legal debounce, used to walk the count up to the wrap.
module tb_bcd_press_counter;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    always #5 CLK = ~CLK;

    bcd_press_counter_if a_if ();
    bcd_press_counter_if b_if ();
    bcd_press_counter_if c_if ();

    bcd_press_counter #(
        .DEBOUNCE_CYCLES(DEB), .ACTIVE_HIGH(1'b1),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut_a (.CLK(CLK), .RST_N(RST_N), .bus(a_if));

    bcd_press_counter #(
        .DEBOUNCE_CYCLES(DEB), .ACTIVE_HIGH(1'b0),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut_b (.CLK(CLK), .RST_N(RST_N), .bus(b_if));

    bcd_press_counter #(
        .DEBOUNCE_CYCLES(2), .ACTIVE_HIGH(1'b1),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut_c (.CLK(CLK), .RST_N(RST_N), .bus(c_if));

    typedef struct packed {
        logic [15:0] num;
        logic        ovf;
    } exp_t;

    typedef struct {
        string       name;
        logic [15:0] pattern;
        int          len;
        bit          exp_event;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   count_a  = 0;
    exp_t sb[$];
    exp_t got;
    vec_t vecs[7];

`ifdef BCD_PRESS_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Model of instance a: advance the count and queue what the next strobe must show.
    task automatic expect_event(input bit clr_now);
        exp_t e;
        int   old;
        old = count_a;
        count_a = clr_now ? 0 : (count_a + 1) % 10000;
        e.num = to_bcd(count_a);
        e.ovf = !clr_now && (old == 9999);
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.exp_event) expect_event(1'b0);
        for (int i = 0; i < v.len; i++) begin
            a_if.btn_raw = v.pattern[i];
            step(1);
        end
        a_if.btn_raw = 1'b0;
        step(12);
        checkOutput({v.name, "_num"}, 32'(a_if.num), 32'(to_bcd(count_a)));
        checkOutput({v.name, "_sb"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic quick_press_a();
        expect_event(1'b0);
        a_if.btn_raw = 1'b1;
        step(5);
        a_if.btn_raw = 1'b0;
        step(6);
    endtask

    task automatic fast_press_c();
        c_if.btn_raw = 1'b1;
        step(2);
        c_if.btn_raw = 1'b0;
        step(2);
    endtask

    // Scoreboard monitor for instance a: every strobe must match the oldest expectation.
    always @(posedge CLK) begin
        #1;
        if (RST_N && a_if.press_pulse) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL sb_pulse actual=unexpected_strobe num=%h required=no_strobe",
                         a_if.num);
            end else begin
                got = sb.pop_front();
                if (a_if.num !== got.num || a_if.overflow !== got.ovf) begin
                    failures++;
                    $display("[TB] FAIL sb_event actual=num %h ovf %b required=num %h ovf %b",
                             a_if.num, a_if.overflow, got.num, got.ovf);
                end
            end
        end else if (RST_N && a_if.overflow) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_overflow actual=1 required=0 (no strobe)");
        end
    end

    initial begin
        vecs[0] = '{name: "clean10",   pattern: 16'h03FF, len: 10, exp_event: 1'b1};
        vecs[1] = '{name: "bounce",    pattern: 16'h0FF5, len: 12, exp_event: 1'b1};
        vecs[2] = '{name: "short3",    pattern: 16'h0007, len: 3,  exp_event: 1'b0};
        vecs[3] = '{name: "glitch1",   pattern: 16'h0001, len: 1,  exp_event: 1'b0};
        vecs[4] = '{name: "exact4",    pattern: 16'h000F, len: 4,  exp_event: 1'b1};
        vecs[5] = '{name: "gap3_3",    pattern: 16'h0077, len: 7,  exp_event: 1'b0};
        vecs[6] = '{name: "relbounce", pattern: 16'h0AFF, len: 12, exp_event: 1'b1};

        a_if.btn_raw = 1'b0; a_if.clr = 1'b0;
        b_if.btn_raw = 1'b1; b_if.clr = 1'b0;
        c_if.btn_raw = 1'b0; c_if.clr = 1'b0;

        // Reset state
        step(3);
        checkOutput("rst_num",   32'(a_if.num), 32'h0);
        checkOutput("rst_press", 32'(a_if.pressed), 32'h0);
        checkOutput("rst_pulse", 32'(a_if.press_pulse), 32'h0);
        checkOutput("rst_ovf",   32'(a_if.overflow), 32'h0);
        RST_N = 1'b1;
        step(3);

        // Clean press: exact latency from pin edge to pressed
        expect_event(1'b0);
        a_if.btn_raw = 1'b1;
        step(5);
        checkOutput("lat_pressed5", 32'(a_if.pressed), 32'h0);
        step(1);
        checkOutput("lat_pressed6", 32'(a_if.pressed), 32'h1);
        checkOutput("lat_pulse6",   32'(a_if.press_pulse), 32'h1);
        checkOutput("lat_num6",     32'(a_if.num), 32'h0001);
        step(1);
        checkOutput("lat_pulse7",   32'(a_if.press_pulse), 32'h0);
        step(3);
        a_if.btn_raw = 1'b0;
        step(10);
        checkOutput("release_pressed", 32'(a_if.pressed), 32'h0);
        checkOutput("release_num",     32'(a_if.num), 32'h0001);

        // Table vectors: bounce, short pulses, boundary widths
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Digit carries
        while (count_a != 9) quick_press_a();
        quick_press_a();
        checkOutput("carry_0010", 32'(a_if.num), 32'h0010);
        while (count_a != 99) quick_press_a();
        quick_press_a();
        checkOutput("carry_0100", 32'(a_if.num), 32'h0100);

        // clr on its own, then clr coincident with a press
        a_if.clr = 1'b1;
        step(1);
        a_if.clr = 1'b0;
        count_a = 0;
        checkOutput("clr_num", 32'(a_if.num), 32'h0);
        repeat (42) quick_press_a();
        checkOutput("preload_0042", 32'(a_if.num), 32'h0042);
        expect_event(1'b1);
        a_if.btn_raw = 1'b1;
        step(5);
        a_if.clr = 1'b1;
        step(1);
        a_if.clr = 1'b0;
        checkOutput("clrpress_num",   32'(a_if.num), 32'h0);
        checkOutput("clrpress_pulse", 32'(a_if.press_pulse), 32'h1);
        checkOutput("clrpress_ovf",   32'(a_if.overflow), 32'h0);
        checkOutput("clrpress_press", 32'(a_if.pressed), 32'h1);
        step(2);
        a_if.btn_raw = 1'b0;
        step(10);

        // Asynchronous reset in the middle of a debounce
        quick_press_a();
        a_if.btn_raw = 1'b1;
        step(4);
        RST_N = 1'b0;
        #1;
        checkOutput("arst_num",   32'(a_if.num), 32'h0);
        checkOutput("arst_press", 32'(a_if.pressed), 32'h0);
        checkOutput("arst_pulse", 32'(a_if.press_pulse), 32'h0);
        checkOutput("arst_ovf",   32'(a_if.overflow), 32'h0);
        a_if.btn_raw = 1'b0;
        sb.delete();
        count_a = 0;
        step(2);
        RST_N = 1'b1;
        step(2);
        expect_event(1'b0);
        a_if.btn_raw = 1'b1;
        step(5);
        checkOutput("rearm_pressed5", 32'(a_if.pressed), 32'h0);
        step(1);
        checkOutput("rearm_pressed6", 32'(a_if.pressed), 32'h1);
        checkOutput("rearm_num",      32'(a_if.num), 32'h0001);
        step(4);
        a_if.btn_raw = 1'b0;
        step(10);

        // Long hold: auto-repeat fires at +0,+20,+25,+30,+35 only when built in
        a_if.clr = 1'b1;
        step(1);
        a_if.clr = 1'b0;
        count_a = 0;
        a_if.btn_raw = 1'b1;
        repeat (AUTO ? 5 : 1) expect_event(1'b0);
        step(6);
        checkOutput("hold_pressed", 32'(a_if.pressed), 32'h1);
        step(20);
        checkOutput("hold_pulse20", 32'(a_if.press_pulse), 32'(AUTO));
        step(11);
        a_if.btn_raw = 1'b0;
        step(15);
        checkOutput("hold_num", 32'(a_if.num), AUTO ? 32'h0005 : 32'h0001);
        checkOutput("hold_sb",  32'(sb.size()), 32'd0);

        // Wrap 9999 -> 0000 on the fast instance
        for (int i = 1; i <= 9999; i++) begin
            fast_press_c();
            if (i == 999)  checkOutput("c_0999", 32'(c_if.num), 32'h0999);
            if (i == 1000) checkOutput("c_1000", 32'(c_if.num), 32'h1000);
        end
        step(4);
        checkOutput("c_9999", 32'(c_if.num), 32'h9999);
        c_if.btn_raw = 1'b1;
        step(2);
        c_if.btn_raw = 1'b0;
        step(2);
        checkOutput("wrap_num",   32'(c_if.num), 32'h0000);
        checkOutput("wrap_ovf",   32'(c_if.overflow), 32'h1);
        checkOutput("wrap_pulse", 32'(c_if.press_pulse), 32'h1);
        step(1);
        checkOutput("wrap_ovf_end",   32'(c_if.overflow), 32'h0);
        checkOutput("wrap_pulse_end", 32'(c_if.press_pulse), 32'h0);

        // Active-low pin: idle-high never counts, a low level is a press
        checkOutput("alow_idle_num",   32'(b_if.num), 32'h0);
        checkOutput("alow_idle_press", 32'(b_if.pressed), 32'h0);
        b_if.btn_raw = 1'b0;
        step(5);
        checkOutput("alow_pressed5", 32'(b_if.pressed), 32'h0);
        step(1);
        checkOutput("alow_pressed6", 32'(b_if.pressed), 32'h1);
        checkOutput("alow_pulse",    32'(b_if.press_pulse), 32'h1);
        checkOutput("alow_num",      32'(b_if.num), 32'h0001);
        step(1);
        b_if.btn_raw = 1'b1;
        step(10);
        checkOutput("alow_rel_press", 32'(b_if.pressed), 32'h0);
        checkOutput("alow_rel_num",   32'(b_if.num), 32'h0001);

        checkOutput("final_sb", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
